// File: rtl/add_arbiter_if.sv
// -----------------------------------------------------------------------------
// add_arbiter_if
//
// Bundles the requester-side operand handshake and the result handshake of the
// shared adder arbiter.
//
//   req_valid  N_REQ    per-requester operand valid
//   req_ready  N_REQ    per-requester accept (one-hot or zero)
//   req_a      N_REQ*W  operand A, requester i at [i*W +: W]
//   req_b      N_REQ*W  operand B, same packing
//   res_valid  1        result valid
//   res_ready  1        result consumer accepts
//   res_sum    W        registered sum (wrapped or saturated)
//   res_cout   1        carry out of the W-bit add
//   res_id     IDW      index of the requester that issued the result
//
// Modports:
//   master : requesters plus result consumer (drive valid/operands/res_ready)
//   slave  : the arbiter itself (drives req_ready and the result port)
// -----------------------------------------------------------------------------
interface add_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int W     = 4,
   parameter int IDW   = $clog2(N_REQ)
);

   logic [N_REQ-1:0]   req_valid;
   logic [N_REQ-1:0]   req_ready;
   logic [N_REQ*W-1:0] req_a;
   logic [N_REQ*W-1:0] req_b;
   logic               res_valid;
   logic               res_ready;
   logic [W-1:0]       res_sum;
   logic               res_cout;
   logic [IDW-1:0]     res_id;

   modport master (
      output req_valid, req_a, req_b, res_ready,
      input  req_ready, res_valid, res_sum, res_cout, res_id
   );

   modport slave (
      input  req_valid, req_a, req_b, res_ready,
      output req_ready, res_valid, res_sum, res_cout, res_id
   );

endinterface

// File: rtl/add_arbiter.sv
// -----------------------------------------------------------------------------
// add_arbiter
//
// Round-robin arbiter in front of one registered W-bit adder shared by N_REQ
// requesters of the 1D-convolution datapath. One requester is granted per
// free cycle; its operands are added and the sum, carry and requester index
// are held on a single valid/ready result port until the consumer takes them.
//
// Ports:
//   ck    clock, everything on the rising edge
//   rst   synchronous reset, active high
//   bus   add_arbiter_if.slave (operand handshakes in, result handshake out)
//
// Parameters:
//   N_REQ  number of requesters (2..8)
//   W      operand / sum width
//   IDW    requester index width, $clog2(N_REQ)
//
// Build option:
//   ADD_ARB_SAT_EN  when defined, a carry saturates res_sum to all ones
//                   (res_cout still reports the carry); otherwise the sum
//                   wraps modulo 2^W.
//
// Priority: the search starts one past the last granted index, so requester 0
// has top priority straight out of reset (pointer resets to N_REQ-1).
// -----------------------------------------------------------------------------
module add_arbiter #(
   parameter int N_REQ = 4,
   parameter int W     = 4,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic         ck,
   input  logic         rst,
   add_arbiter_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,   // no result held
      BUSY = 1'b1    // result held, res_valid high
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t         state_q, state_d;
   logic [IDW-1:0] ptr_q;       // last granted requester
   logic [W-1:0]   sum_q;
   logic           cout_q;
   logic [IDW-1:0] id_q;

   // ---------------------------------------------------------------------------
   // Combinational grant / datapath signals
   // ---------------------------------------------------------------------------
   logic           grant_hit;   // some requester is valid
   logic [IDW-1:0] grant_id;    // round-robin winner
   int unsigned    scan_idx;
   logic           slot_free;
   logic           accept;
   logic [W-1:0]   a_sel;
   logic [W-1:0]   b_sel;
   logic [W:0]     sum_full;
   logic [W-1:0]   sum_next;
   logic           cout_next;

   // Round-robin search: offsets 1..N_REQ from the pointer, so the last
   // winner is looked at last and a lone valid requester always wins.
   // NOTE: every variable written here gets a default first, so no path
   // leaves a previous value implied and no latch is inferred.
   always_comb begin
      grant_hit = 1'b0;
      grant_id  = '0;
      scan_idx  = 0;
      for (int off = 1; off <= N_REQ; off++) begin
         scan_idx = (int'(ptr_q) + off) % N_REQ;
         if (!grant_hit && bus.req_valid[scan_idx]) begin
            grant_hit = 1'b1;
            grant_id  = IDW'(scan_idx);
         end
      end
   end

   // The adder slot frees up in the same cycle the held result is retired,
   // which is what gives one result per cycle under continuous demand.
   assign slot_free = (state_q == IDLE) || bus.res_ready;

   // A request seen while rst is high must never be accepted.
   assign accept = grant_hit && slot_free && !rst;

   assign bus.req_ready = accept ? (N_REQ'(1) << grant_id) : '0;

   // Operand mux driven only by the winner index; the operands reach nothing
   // but the result registers, so no output depends on them combinationally.
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_id == IDW'(i)) begin
            a_sel = bus.req_a[i*W +: W];
            b_sel = bus.req_b[i*W +: W];
         end
      end
   end

   // Full W+1-bit add of zero-extended operands.
   assign sum_full  = {1'b0, a_sel} + {1'b0, b_sel};
   assign cout_next = sum_full[W];

`ifdef ADD_ARB_SAT_EN
   assign sum_next = sum_full[W] ? {W{1'b1}} : sum_full[W-1:0];
`else
   assign sum_next = sum_full[W-1:0];
`endif

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = BUSY;
         end
         BUSY: begin
            // Retire the held result; stay busy when a new one is loaded on
            // the same edge (back-to-back).
            if (bus.res_ready) state_d = accept ? BUSY : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge ck) begin
      if (rst) begin
         // Result registers are cleared too: a held result is discarded and
         // the port reads as zero after reset.
         state_q <= IDLE;
         ptr_q   <= IDW'(N_REQ - 1);
         sum_q   <= '0;
         cout_q  <= 1'b0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            sum_q  <= sum_next;
            cout_q <= cout_next;
            id_q   <= grant_id;
            ptr_q  <= grant_id;
         end
      end
   end

   assign bus.res_valid = (state_q == BUSY);
   assign bus.res_sum   = sum_q;
   assign bus.res_cout  = cout_q;
   assign bus.res_id    = id_q;

endmodule

// File: doc/add_arbiter.md
# add_arbiter

Round-robin arbiter and sequencer sharing one registered W-bit adder among N_REQ requesters in the 1D-convolution datapath. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, registers the sum and carry, and returns the result tagged with the requester index on a single valid/ready result port. It sits between the convolution tap/accumulate logic and the shared adder resource.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W, 4, operand and sum width
- IDW, $clog2(N_REQ), width of requester index
- ck  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active high
- req_valid  in  N_REQ  per-requester operand valid
- req_ready  out  N_REQ  per-requester accept; at most one bit high (one-hot or zero)
- req_a  in  N_REQ*W  operand A; requester i at [i*W +: W]
- req_b  in  N_REQ*W  operand B; same packing
- res_valid  out  1  result valid
- res_ready  in  1  result consumer accepts
- res_sum  out  W  (a+b) mod 2^W (or saturated, see Configuration)
- res_cout  out  1  carry out of the W-bit add
- res_id  out  IDW  index of requester that issued this result

## Operation
- States: IDLE (no result held), BUSY (result held, res_valid=1).
- Slot free = (state==IDLE) or (state==BUSY and res_ready==1).
- Grant, combinational: search req_valid starting at index (ptr+1) mod N_REQ and wrapping; first set bit wins. req_ready[g]=1 only if slot free and req_valid[g]=1; otherwise req_ready=0.
- Accept = req_valid[g] & req_ready[g]. On accept: res_sum/res_cout ← a_g+b_g, res_id ← g, ptr ← g, state ← BUSY.
- BUSY with res_ready=1 and no accept → IDLE; res_valid falls next cycle.
- BUSY with res_ready=1 and accept → stays BUSY; new result is loaded in the same edge that retires the old one (back-to-back).
- BUSY with res_ready=0: req_ready=0; result registers hold; ptr holds.
- Arithmetic: full W+1-bit sum of zero-extended operands; res_sum = low W bits, res_cout = bit W.
- Requesters may drop req_valid without being granted; there is no lock and no starvation beyond N_REQ-1 grants.

## Timing
- Reset (rst=1 at edge): state=IDLE, res_valid=0, res_sum=0, res_cout=0, res_id=0, ptr=N_REQ-1 (requester 0 has top priority). req_ready=0 during the rst cycle regardless of req_valid.
- Latency: accept at edge k → res_valid=1 with result from after edge k (visible in cycle k+1).
- Throughput: 1 result/cycle while res_ready=1 and requests are pending.
- req_ready depends combinationally on req_valid, ptr, state and res_ready. No combinational path from req_a/req_b to any output.
- Reset mid-operation: a held result is discarded without handshake. A request presented in the rst cycle is not accepted.
- Single requester valid: granted every free cycle regardless of ptr.

## Configuration
- ADD_ARB_SAT_EN defined: unsigned saturation. If the carry is set, res_sum = all ones (2^W-1) and res_cout=1; otherwise as normal.
- Not defined: wrap-around sum (mod 2^W), res_cout = carry.

## Test plan
- Reset then req_valid=4'b0001, a0=5, b0=6, res_ready=1 → req_ready=4'b0001 in the same cycle. Next cycle: res_valid=1, res_sum=11, res_cout=0, res_id=0.
- All four valid, res_ready=1 held, operands (2,11),(7,5),(4,6),(1,1) → grants 0,1,2,3,0… on consecutive cycles; results 13,12,10,2 with ids 0..3 back-to-back.
- Overflow: a=9, b=8 → without macro res_sum=1, res_cout=1. With ADD_ARB_SAT_EN: res_sum=15, res_cout=1.
- Backpressure: result pending, res_ready=0 for 3 cycles with req_valid=4'b0110 → req_ready=0 and result stable for those cycles. Raising res_ready retires the result and grants requester 1 in the same cycle.
- Fairness: requester 0 held valid continuously, requester 2 asserted once → requester 2 granted within the next grant after its current holder (≤1 intervening grant to 0).
- Reset while BUSY with res_ready=0 → next cycle res_valid=0, res_sum=0, res_id=0. The first post-reset grant goes to the lowest valid index.
